// File: rtl/fifo_rr_drain_arb_pkg.sv
// fifo_rr_drain_arb_pkg: FSM encoding and width helper shared by the drain arbiter files
package fifo_rr_drain_arb_pkg;
  typedef enum logic {ARB_IDLE = 1'b0, ARB_BURST = 1'b1} arb_state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/fifo_rr_drain_arb_rr_pick.sv
// rr_pick: combinational round-robin pick of the first requester at or above ptr, with wrap
module rr_pick import fifo_rr_drain_arb_pkg::*; #(
  parameter int NUM_PORTS = 4
) (
  input  logic [NUM_PORTS-1:0]        req_i,
  input  logic [clog2(NUM_PORTS)-1:0] ptr_i,
  output logic [NUM_PORTS-1:0]        win_o,
  output logic [clog2(NUM_PORTS)-1:0] idx_o,
  output logic                        any_o
);
  localparam int PW = clog2(NUM_PORTS);
  // walk ports ptr, ptr+1, ... modulo NUM_PORTS; the first requester seen wins
  always_comb begin
    logic [PW-1:0] pi;
    logic found;
    win_o = '0;
    idx_o = '0;
    found = 1'b0;
    pi = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      pi = PW'((int'(ptr_i) + k) % NUM_PORTS);
      if (!found && req_i[pi]) begin
        win_o[pi] = 1'b1;
        idx_o = pi;
        found = 1'b1;
      end
    end
    any_o = |req_i;
  end
endmodule

// File: rtl/fifo_rr_drain_arb.sv
// fifo_rr_drain_arb: drains NUM_PORTS FWFT FIFOs in round-robin bursts into one registered valid/ready stream
module fifo_rr_drain_arb import fifo_rr_drain_arb_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PORTS  = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             fifo_empty_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  fifo_data_i,
  output logic [NUM_PORTS-1:0]             fifo_rd_en_o,
  output logic [DATA_WIDTH-1:0]            out_data_o,
  output logic [clog2(NUM_PORTS)-1:0]      out_port_o,
  output logic                             out_last_o,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [NUM_PORTS-1:0]             grant_o,
  output logic                             busy_o
);
  localparam int PW = clog2(NUM_PORTS);
  localparam int CW = clog2(BURST_LEN + 1);
  arb_state_e state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d, pick_win;
  logic [PW-1:0] gidx_q, gidx_d, ptr_q, ptr_d, pick_idx, ptr_inc, port_q, port_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, head_data;
  logic last_q, last_d, valid_q, valid_d;
  logic any_req, idle, head_empty, slot_free, last_pop, pop, burst_end;

  rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .req_i(~fifo_empty_i),
    .ptr_i(ptr_q),
    .win_o(pick_win),
    .idx_o(pick_idx),
    .any_o(any_req)
  );

  // look at the granted FIFO head and decide pop / burst release; no pops while reset is held
  always_comb begin
    idle = state_q == ARB_IDLE;
    head_empty = fifo_empty_i[gidx_q];
    head_data = fifo_data_i[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];
    slot_free = !valid_q || out_ready_i;
    last_pop = cnt_q == CW'(BURST_LEN - 1);
    pop = rst_n && !idle && !head_empty && slot_free;
    burst_end = !idle && (head_empty || (pop && last_pop));
    ptr_inc = gidx_q == PW'(NUM_PORTS - 1) ? '0 : gidx_q + PW'(1);
  end

  // IDLE grants as soon as any FIFO has data; BURST runs until the burst fills or the FIFO runs dry
  always_comb state_d = idle ? (any_req ? ARB_BURST : ARB_IDLE) : (burst_end ? ARB_IDLE : ARB_BURST);

  // grant/pointer/count bookkeeping and the output register, which holds under backpressure
  always_comb begin
    grant_d = idle ? pick_win : (burst_end ? '0 : grant_q);
    gidx_d = idle ? pick_idx : gidx_q;
    cnt_d = idle ? '0 : (pop ? cnt_q + CW'(1) : cnt_q);
    ptr_d = burst_end ? ptr_inc : ptr_q;
    valid_d = pop || (valid_q && !out_ready_i);
    data_d = pop ? head_data : data_q;
    port_d = pop ? gidx_q : port_q;
    last_d = pop ? last_pop : last_q;
  end

  // all state, cleared by the synchronous active-low reset (a held output word is dropped)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      gidx_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      valid_q <= 1'b0;
      data_q <= '0;
      port_q <= '0;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q <= gidx_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      valid_q <= valid_d;
      data_q <= data_d;
      port_q <= port_d;
      last_q <= last_d;
    end
  end

  // pop strobe goes only to the granted FIFO; everything else mirrors registers
  always_comb begin
    fifo_rd_en_o = pop ? grant_q : '0;
    grant_o = grant_q;
    busy_o = !idle;
    out_data_o = data_q;
    out_port_o = port_q;
    out_last_o = last_q;
    out_valid_o = valid_q;
  end
endmodule

// File: tb/tb_fifo_rr_drain_arb.sv
// tb_fifo_rr_drain_arb: FIFO queues + behavioural scheduler model, vector table and directed corner sequences
module tb_fifo_rr_drain_arb;
  localparam int NP = 4;
  localparam int BL = 4;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NP-1:0] fifo_empty_i = '1;
  logic [NP*DW-1:0] fifo_data_i = '0;
  logic [NP-1:0] fifo_rd_en_o, grant_o;
  logic [DW-1:0] out_data_o;
  logic [1:0] out_port_o;
  logic out_last_o, out_valid_o, busy_o;
  logic out_ready_i = 1'b1;

  typedef struct packed {logic r; logic [3:0] rd; logic [3:0] gnt; logic v; logic [7:0] d; logic l;} vec_t;
  typedef struct packed {logic [1:0] p; logic [7:0] d; logic l;} word_t;

  logic [7:0] q[NP][$];
  word_t wlog[$];
  vec_t tv[18];
  int n_chk = 0;
  int n_pass = 0;
  logic m_busy = 1'b0, m_v = 1'b0, m_l = 1'b0;
  int m_g = 0, m_cnt = 0, m_ptr = 0, m_p = 0;
  logic [7:0] m_d = 8'h00;
  logic [3:0] rd_cap = '0;

  fifo_rr_drain_arb #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .BURST_LEN(BL)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fifo_empty_i(fifo_empty_i),
    .fifo_data_i(fifo_data_i),
    .fifo_rd_en_o(fifo_rd_en_o),
    .out_data_o(out_data_o),
    .out_port_o(out_port_o),
    .out_last_o(out_last_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .grant_o(grant_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // present FIFO heads, compare the DUT with the model, then advance the model by one clock
  task automatic prep();
    logic [31:0] act, exp;
    logic pop;
    int nxt;
    for (int p = 0; p < NP; p++) begin
      fifo_empty_i[p] = q[p].size() == 0;
      fifo_data_i[p*DW +: DW] = q[p].size() > 0 ? q[p][0] : 8'h00;
    end
    #1;
    pop = rst_n && m_busy && q[m_g].size() > 0 && (!m_v || out_ready_i);
    exp = {11'h0, pop ? 4'(1 << m_g) : 4'h0, m_busy ? 4'(1 << m_g) : 4'h0, m_busy, m_v, m_d, 2'(m_p), m_l};
    act = {11'h0, fifo_rd_en_o, grant_o, busy_o, out_valid_o, out_data_o, out_port_o, out_last_o};
    chk("cycle", act, exp);
    if (out_valid_o && out_ready_i) wlog.push_back({out_port_o, out_data_o, out_last_o});
    rd_cap = fifo_rd_en_o;
    if (!rst_n) begin
      m_busy = 0; m_g = 0; m_cnt = 0; m_ptr = 0; m_v = 0; m_d = 0; m_p = 0; m_l = 0;
    end else if (!m_busy) begin
      nxt = -1;
      for (int k = 0; k < NP; k++)
        if (nxt < 0 && q[(m_ptr + k) % NP].size() > 0) nxt = (m_ptr + k) % NP;
      if (nxt >= 0) begin m_g = nxt; m_busy = 1; m_cnt = 0; end
      if (out_ready_i) m_v = 0;
    end else begin
      if (pop) begin
        m_d = q[m_g][0]; m_p = m_g; m_v = 1; m_l = (m_cnt == BL - 1); m_cnt++;
      end else if (out_ready_i) m_v = 0;
      if (q[m_g].size() == 0 || (pop && m_l)) begin m_busy = 0; m_ptr = (m_g + 1) % NP; end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++)
      if (rd_cap[p]) begin
        chk("pop_nonempty", 32'(q[p].size() > 0), 32'd1);
        if (q[p].size() > 0) void'(q[p].pop_front());
      end
  endtask

  task automatic step();
    prep();
    adv();
  endtask

  task automatic do_reset();
    for (int p = 0; p < NP; p++) q[p].delete();
    rst_n = 1'b0;
    out_ready_i = 1'b1;
    step();
    rst_n = 1'b1;
    wlog.delete();
  endtask

  initial begin
    tv = '{
      '{1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0},
      '{1'b1, 4'h4, 4'h4, 1'b0, 8'h00, 1'b0},
      '{1'b1, 4'h4, 4'h4, 1'b1, 8'h10, 1'b0},
      '{1'b1, 4'h4, 4'h4, 1'b1, 8'h11, 1'b0},
      '{1'b1, 4'h4, 4'h4, 1'b1, 8'h12, 1'b0},
      '{1'b1, 4'h0, 4'h0, 1'b1, 8'h13, 1'b1},
      '{1'b1, 4'h4, 4'h4, 1'b0, 8'h00, 1'b0},
      '{1'b1, 4'h4, 4'h4, 1'b1, 8'h14, 1'b0},
      '{1'b0, 4'h0, 4'h4, 1'b1, 8'h15, 1'b0},
      '{1'b0, 4'h0, 4'h4, 1'b1, 8'h15, 1'b0},
      '{1'b0, 4'h0, 4'h4, 1'b1, 8'h15, 1'b0},
      '{1'b1, 4'h4, 4'h4, 1'b1, 8'h15, 1'b0},
      '{1'b1, 4'h4, 4'h4, 1'b1, 8'h16, 1'b0},
      '{1'b1, 4'h0, 4'h0, 1'b1, 8'h17, 1'b1},
      '{1'b1, 4'h4, 4'h4, 1'b0, 8'h00, 1'b0},
      '{1'b1, 4'h4, 4'h4, 1'b1, 8'h18, 1'b0},
      '{1'b1, 4'h0, 4'h4, 1'b1, 8'h19, 1'b0},
      '{1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0}
    };
    repeat (2) @(posedge clk);
    #1;
    // reset held with every FIFO non-empty: nothing pops, outputs stay cleared
    for (int p = 0; p < NP; p++) begin q[p].push_back(8'(p)); q[p].push_back(8'(p + 8)); end
    for (int c = 0; c < 3; c++) begin
      prep();
      chk("t1 rd_en", 32'(fifo_rd_en_o), 32'h0);
      chk("t1 outs", {grant_o, busy_o, out_valid_o, out_data_o, out_port_o, out_last_o}, 32'h0);
      adv();
    end
    rst_n = 1'b1;
    step();
    prep();
    chk("t1 first grant", 32'(grant_o), 32'h1);
    adv();
    // single source, bursts of four with a backpressure stall inside the second burst
    do_reset();
    for (int i = 0; i < 10; i++) q[2].push_back(8'h10 + 8'(i));
    for (int i = 0; i < 18; i++) begin
      out_ready_i = tv[i].r;
      prep();
      chk($sformatf("t2 row%0d ctl", i), {fifo_rd_en_o, grant_o, out_valid_o}, {tv[i].rd, tv[i].gnt, tv[i].v});
      if (tv[i].v) chk($sformatf("t2 row%0d word", i), {out_data_o, out_last_o, out_port_o}, {tv[i].d, tv[i].l, 2'd2});
      adv();
    end
    // all four ports full: strict rotation, four words per grant, last on every fourth
    do_reset();
    for (int p = 0; p < NP; p++) for (int i = 0; i < 8; i++) q[p].push_back(8'(p * 16 + i));
    for (int c = 0; c < 200 && wlog.size() < 32; c++) step();
    chk("t3 count", 32'(wlog.size()), 32'd32);
    for (int n = 0; n < 32 && n < wlog.size(); n++)
      chk($sformatf("t3 word%0d", n), 32'(wlog[n]),
          32'({2'((n / 4) % 4), 8'(((n / 4) % 4) * 16 + (n / 16) * 4 + n % 4), n % 4 == 3}));
    // port 1 runs dry after two words: early release without last, then port 2
    do_reset();
    q[0].push_back(8'hA0);
    q[1].push_back(8'hB0); q[1].push_back(8'hB1);
    q[2].push_back(8'hC0); q[2].push_back(8'hC1);
    q[3].push_back(8'hD0); q[3].push_back(8'hD1);
    for (int c = 0; c < 100 && wlog.size() < 4; c++) step();
    chk("t5 count", 32'(wlog.size() >= 4), 32'd1);
    if (wlog.size() >= 4) begin
      chk("t5 w0", 32'(wlog[0]), 32'({2'd0, 8'hA0, 1'b0}));
      chk("t5 w1", 32'(wlog[1]), 32'({2'd1, 8'hB0, 1'b0}));
      chk("t5 w2", 32'(wlog[2]), 32'({2'd1, 8'hB1, 1'b0}));
      chk("t5 next port", 32'(wlog[3].p), 32'd2);
    end
    // reset in the middle of a port 3 burst: output dropped, pointer back to 0
    do_reset();
    for (int i = 0; i < 6; i++) q[3].push_back(8'hE0 + 8'(i));
    for (int c = 0; c < 50 && wlog.size() < 2; c++) step();
    chk("t6 started", 32'(wlog.size()), 32'd2);
    q[1].push_back(8'h51); q[1].push_back(8'h52);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("t6 valid cleared", 32'(out_valid_o), 32'd0);
    step();
    chk("t6 grant after reset", 32'(grant_o), 32'h2);
    // random traffic, backpressure and occasional resets against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < NP; p++)
        if (q[p].size() < 8 && $urandom_range(0, 9) < 3) q[p].push_back(8'($urandom));
      out_ready_i = $urandom_range(0, 3) != 0;
      rst_n = $urandom_range(0, 299) != 0;
      step();
    end
    rst_n = 1'b1;
    out_ready_i = 1'b1;
    for (int c = 0; c < 200; c++) step();
    chk("drained", 32'(q[0].size() + q[1].size() + q[2].size() + q[3].size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
